keycode_decoder: RTL and testbench

Cleans and decodes the 8-bit USB HID keycode exported by `usb_system` into per-player action signals for the two `ball` instances and the `block_SM` level state machine. It sits between the keycode PIO and the game logic. The block:
- registers and debounces the raw code,
- maps it to eight game actions,
- produces level-held, one-cycle press, and frame-aligned press outputs, with the frame boundary taken from the VGA `vs` pulse.

---
 rtl/keycode_decoder.sv | 166 ++++++++++++++++
 tb/tb_keycode_decoder.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keycode_decoder.sv
// keycode_decoder: registers and debounces the raw USB HID keycode, decodes it
// into eight game actions (held / one-cycle press / per-frame press) and
// derives a frame tick from the rising edge of VGA vsync.
module keycode_decoder #(
    parameter int unsigned STABLE_CYCLES = 50000
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] keycode,
    input  logic       vs,
    output logic [7:0] action_held,
    output logic [7:0] action_press,
    output logic [7:0] frame_press,
    output logic       frame_tick,
    output logic [7:0] accepted_code
);

    localparam int unsigned CODE_W = 8;
    localparam int unsigned CNT_W  = 16;
    localparam logic [CNT_W-1:0] STABLE_N = CNT_W'(STABLE_CYCLES);
    // With a one-edge requirement a freshly seen code is accepted immediately.
    localparam bit ACCEPT_FIRST = (STABLE_CYCLES <= 32'd1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CAND = 2'd1,
        HELD = 2'd2
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [CODE_W-1:0]   code_q;
    logic [CODE_W-1:0]   cand_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                vs1_q;
    logic                vs2_q;
    logic                vs3_q;
    logic [CODE_W-1:0]   sticky_q;

    logic load_c;
    logic accept_c;
    logic inc_c;
    logic release_c;

    // Keycode to action bit map; unmapped codes give no action.
    function automatic logic [CODE_W-1:0] action_map(input logic [CODE_W-1:0] code);
        logic [CODE_W-1:0] a;
        a = '0;
        case (code)
            8'h04:   a[0] = 1'b1;
            8'h07:   a[1] = 1'b1;
            8'h1A:   a[2] = 1'b1;
            8'h50:   a[3] = 1'b1;
            8'h4F:   a[4] = 1'b1;
            8'h52:   a[5] = 1'b1;
            8'h28:   a[6] = 1'b1;
            8'h2C:   a[7] = 1'b1;
            default: a = '0;
        endcase
        return a;
    endfunction

    // Debounce decisions: load a new candidate, count, accept or release.
    always_comb begin
        state_d   = state_q;
        load_c    = 1'b0;
        accept_c  = 1'b0;
        inc_c     = 1'b0;
        release_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (code_q != '0) begin
                    load_c = 1'b1;
                end
            end
            CAND: begin
                if (code_q == '0) begin
                    state_d = IDLE;
                end else if (code_q != cand_q) begin
                    load_c = 1'b1;
                end else if (cnt_q + CNT_W'(1) == STABLE_N) begin
                    accept_c = 1'b1;
                end else begin
                    inc_c = 1'b1;
                end
            end
            HELD: begin
                if (code_q != cand_q) begin
                    release_c = 1'b1;
                    if (code_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        load_c = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (load_c) begin
            if (ACCEPT_FIRST) begin
                accept_c = 1'b1;
            end else begin
                state_d = CAND;
            end
        end
        if (accept_c) begin
            state_d = HELD;
        end
    end

    // Input register, debounce state and action outputs.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q       <= IDLE;
            code_q        <= '0;
            cand_q        <= '0;
            cnt_q         <= '0;
            action_held   <= '0;
            action_press  <= '0;
            accepted_code <= '0;
        end else begin
            state_q      <= state_d;
            code_q       <= keycode;
            action_press <= '0;
            if (load_c) begin
                cand_q <= code_q;
                cnt_q  <= CNT_W'(1);
            end else if (inc_c) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (release_c) begin
                action_held <= '0;
            end
            if (accept_c) begin
                cand_q        <= code_q;
                accepted_code <= code_q;
                action_held   <= action_map(code_q);
                action_press  <= action_map(code_q);
            end
        end
    end

    // Vsync synchroniser, rising-edge tick and per-frame press accumulator.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            vs1_q       <= 1'b0;
            vs2_q       <= 1'b0;
            vs3_q       <= 1'b0;
            frame_tick  <= 1'b0;
            sticky_q    <= '0;
            frame_press <= '0;
        end else begin
            vs1_q      <= vs;
            vs2_q      <= vs1_q;
            vs3_q      <= vs2_q;
            frame_tick <= vs2_q & ~vs3_q;
            if (frame_tick) begin
                frame_press <= sticky_q | action_press;
                sticky_q    <= '0;
            end else begin
                sticky_q <= sticky_q | action_press;
            end
        end
    end

endmodule

// File: tb/tb_keycode_decoder.sv
// tb_keycode_decoder: scenario tasks plus randomized traffic, checked against
// a run-length / event-queue reference model of the decoder.
module tb_keycode_decoder;

    localparam int unsigned SC = 4;

    logic       Clk;
    logic       Reset;
    logic [7:0] keycode;
    logic       vs;
    logic [7:0] action_held;
    logic [7:0] action_press;
    logic [7:0] frame_press;
    logic       frame_tick;
    logic [7:0] accepted_code;

    keycode_decoder #(.STABLE_CYCLES(SC)) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .keycode       (keycode),
        .vs            (vs),
        .action_held   (action_held),
        .action_press  (action_press),
        .frame_press   (frame_press),
        .frame_tick    (frame_tick),
        .accepted_code (accepted_code)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int errors = 0;
    int checks = 0;

    // Reference model state: run length of the registered code, event queues.
    logic [7:0] m_cq;
    logic [7:0] m_cur;
    int         m_run;
    int         m_cycle;
    logic [7:0] m_held;
    logic [7:0] m_press;
    logic [7:0] m_fp;
    logic [7:0] m_acc;
    logic       m_tick;
    logic       m_vs_prev;
    logic [7:0] win[$];
    int         tick_at[$];

    logic [32:0] dut_vec;
    logic [32:0] mdl_vec;
    assign dut_vec = {action_held, action_press, frame_press, frame_tick, accepted_code};
    assign mdl_vec = {m_held, m_press, m_fp, m_tick, m_acc};

    function automatic logic [7:0] amap(input logic [7:0] c);
        case (c)
            8'h04:   return 8'h01;
            8'h07:   return 8'h02;
            8'h1A:   return 8'h04;
            8'h50:   return 8'h08;
            8'h4F:   return 8'h10;
            8'h52:   return 8'h20;
            8'h28:   return 8'h40;
            8'h2C:   return 8'h80;
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_reset();
        m_cq = 8'h00; m_cur = 8'h00; m_run = 0;
        m_held = 8'h00; m_press = 8'h00; m_fp = 8'h00; m_acc = 8'h00;
        m_tick = 1'b0; m_vs_prev = 1'b0;
        win.delete();
        tick_at.delete();
    endtask

    // One clock edge of the model; kc/v are the inputs sampled at this edge.
    task automatic model_edge(input logic [7:0] kc, input logic v);
        logic [7:0] acc;
        m_cycle++;
        if (m_tick) begin
            acc = 8'h00;
            foreach (win[i]) acc = acc | win[i];
            m_fp = acc;
            win.delete();
        end
        if (m_cq != 8'h00 && m_cq == m_cur) m_run++;
        else if (m_cq != 8'h00)             m_run = 1;
        else                                 m_run = 0;
        m_cur   = m_cq;
        m_cq    = kc;
        m_held  = (m_run >= int'(SC)) ? amap(m_cur) : 8'h00;
        m_press = (m_run == int'(SC)) ? amap(m_cur) : 8'h00;
        if (m_run == int'(SC)) m_acc = m_cur;
        win.push_back(m_press);
        if (v && !m_vs_prev) tick_at.push_back(m_cycle + 2);
        m_vs_prev = v;
        m_tick = 1'b0;
        if (tick_at.size() > 0) begin
            if (tick_at[0] == m_cycle) begin
                m_tick = 1'b1;
                void'(tick_at.pop_front());
            end
        end
    endtask

    // Drive inputs at a falling edge, advance one rising edge, return at the next falling edge.
    task automatic step(input logic [7:0] kc, input logic v);
        keycode = kc;
        vs      = v;
        @(posedge Clk);
        model_edge(kc, v);
        @(negedge Clk);
    endtask

    task automatic test_reset();
        Reset = 1'b0; keycode = 8'h00; vs = 1'b0;
        model_reset();
        repeat (2) @(negedge Clk);
        checks++;
        if (dut_vec !== 33'd0) begin
            errors++; $display("FAIL reset_values: got=%h exp=%h", dut_vec, 33'd0);
        end
        Reset = 1'b1;
    endtask

    task automatic test_stable_press();
        int npress = 0; int pstep = -1; logic [7:0] pval = 8'h00;
        repeat (2) step(8'h00, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            step(8'h04, 1'b0);
            checks++;
            if (dut_vec !== mdl_vec) begin
                errors++; $display("FAIL stable_press step%0d: got=%h exp=%h", i, dut_vec, mdl_vec);
            end
            if (action_press != 8'h00) begin npress++; pstep = i; pval = action_press; end
        end
        checks++;
        if (npress != 1 || pstep != int'(SC) + 1 || pval !== 8'h01) begin
            errors++; $display("FAIL stable_press_pulse: got count=%0d step=%0d val=%h exp count=1 step=%0d val=01", npress, pstep, pval, int'(SC) + 1);
        end
        checks++;
        if (action_held !== 8'h01 || accepted_code !== 8'h04) begin
            errors++; $display("FAIL stable_press_held: got held=%h acc=%h exp held=01 acc=04", action_held, accepted_code);
        end
        step(8'h00, 1'b0);
        checks++;
        if (action_held !== 8'h01) begin
            errors++; $display("FAIL release_first_edge: got held=%h exp 01", action_held);
        end
        step(8'h00, 1'b0);
        checks++;
        if (action_held !== 8'h00 || accepted_code !== 8'h04) begin
            errors++; $display("FAIL release_second_edge: got held=%h acc=%h exp held=00 acc=04", action_held, accepted_code);
        end
    endtask

    task automatic test_bounce();
        int npress = 0; int pstep = -1; logic [7:0] pval = 8'h00;
        for (int i = 0; i < 20; i++) begin
            step(((i / 2) % 2 == 0) ? 8'h07 : 8'h00, 1'b0);
            checks++;
            if (dut_vec !== mdl_vec) begin
                errors++; $display("FAIL bounce_toggle step%0d: got=%h exp=%h", i, dut_vec, mdl_vec);
            end
            if (action_press != 8'h00) npress++;
        end
        checks++;
        if (npress != 0 || accepted_code !== 8'h04) begin
            errors++; $display("FAIL bounce_no_press: got presses=%0d acc=%h exp presses=0 acc=04", npress, accepted_code);
        end
        for (int i = 1; i <= 8; i++) begin
            step(8'h07, 1'b0);
            checks++;
            if (dut_vec !== mdl_vec) begin
                errors++; $display("FAIL bounce_hold step%0d: got=%h exp=%h", i, dut_vec, mdl_vec);
            end
            if (action_press != 8'h00) begin npress++; pstep = i; pval = action_press; end
        end
        checks++;
        if (npress != 1 || pstep != int'(SC) + 1 || pval !== 8'h02) begin
            errors++; $display("FAIL bounce_final_press: got count=%0d step=%0d val=%h exp count=1 step=%0d val=02", npress, pstep, pval, int'(SC) + 1);
        end
    endtask

    task automatic test_direct_change();
        int npress = 0; int pstep = -1; logic [7:0] pval = 8'h00;
        repeat (6) step(8'h50, 1'b0);
        checks++;
        if (action_held !== 8'h08) begin
            errors++; $display("FAIL change_first_held: got held=%h exp 08", action_held);
        end
        for (int i = 1; i <= 8; i++) begin
            step(8'h52, 1'b0);
            checks++;
            if (dut_vec !== mdl_vec) begin
                errors++; $display("FAIL direct_change step%0d: got=%h exp=%h", i, dut_vec, mdl_vec);
            end
            if (i == 1 && action_held !== 8'h08) begin
                errors++; $display("FAIL change_held_step1: got held=%h exp 08", action_held);
            end
            if (i == 2 && action_held !== 8'h00) begin
                errors++; $display("FAIL change_held_step2: got held=%h exp 00", action_held);
            end
            if (action_press != 8'h00) begin npress++; pstep = i; pval = action_press; end
        end
        checks++;
        if (npress != 1 || pstep != int'(SC) + 1 || pval !== 8'h20 || action_held !== 8'h20) begin
            errors++; $display("FAIL change_second_press: got count=%0d step=%0d val=%h held=%h exp count=1 step=%0d val=20 held=20", npress, pstep, pval, action_held, int'(SC) + 1);
        end
    endtask

    task automatic test_unmapped();
        int npress = 0;
        repeat (2) step(8'h00, 1'b0);
        for (int i = 1; i <= 7; i++) begin
            step(8'h1D, 1'b0);
            checks++;
            if (dut_vec !== mdl_vec) begin
                errors++; $display("FAIL unmapped step%0d: got=%h exp=%h", i, dut_vec, mdl_vec);
            end
            if (action_press != 8'h00) npress++;
        end
        checks++;
        if (accepted_code !== 8'h1D || action_held !== 8'h00 || npress != 0) begin
            errors++; $display("FAIL unmapped_result: got acc=%h held=%h presses=%0d exp acc=1D held=00 presses=0", accepted_code, action_held, npress);
        end
    endtask

    task automatic test_frame();
        logic [7:0] kseq [0:15];
        kseq = '{8'h04, 8'h04, 8'h04, 8'h04, 8'h04, 8'h04, 8'h00, 8'h00,
                 8'h2C, 8'h2C, 8'h2C, 8'h2C, 8'h2C, 8'h2C, 8'h00, 8'h00};
        // Flush everything pressed so far into one published frame.
        for (int i = 0; i < 8; i++) begin
            step(8'h00, (i < 4) ? 1'b1 : 1'b0);
            checks++;
            if (dut_vec !== mdl_vec) begin
                errors++; $display("FAIL frame_flush step%0d: got=%h exp=%h", i, dut_vec, mdl_vec);
            end
        end
        for (int i = 0; i < 16; i++) begin
            step(kseq[i], 1'b0);
            checks++;
            if (dut_vec !== mdl_vec) begin
                errors++; $display("FAIL frame_presses step%0d: got=%h exp=%h", i, dut_vec, mdl_vec);
            end
        end
        for (int i = 1; i <= 4; i++) begin
            step(8'h00, 1'b1);
            checks++;
            if (dut_vec !== mdl_vec) begin
                errors++; $display("FAIL frame_vs_rise step%0d: got=%h exp=%h", i, dut_vec, mdl_vec);
            end
            if (i == 3 && frame_tick !== 1'b1) begin
                errors++; $display("FAIL frame_tick_timing: got tick=%b exp 1", frame_tick);
            end
        end
        checks++;
        if (frame_press !== 8'h81 || frame_tick !== 1'b0) begin
            errors++; $display("FAIL frame_publish: got fp=%h tick=%b exp fp=81 tick=0", frame_press, frame_tick);
        end
        repeat (3) step(8'h00, 1'b0);
        repeat (4) step(8'h00, 1'b1);
        checks++;
        if (frame_press !== 8'h00) begin
            errors++; $display("FAIL frame_empty: got fp=%h exp 00", frame_press);
        end
        // Press pulse lands on the same cycle as the tick.
        for (int i = 1; i <= 6; i++) begin
            step(8'h07, (i >= 3) ? 1'b1 : 1'b0);
            checks++;
            if (dut_vec !== mdl_vec) begin
                errors++; $display("FAIL frame_coincide step%0d: got=%h exp=%h", i, dut_vec, mdl_vec);
            end
            if (i == 5 && (action_press !== 8'h02 || frame_tick !== 1'b1)) begin
                errors++; $display("FAIL coincide_align: got press=%h tick=%b exp press=02 tick=1", action_press, frame_tick);
            end
        end
        checks++;
        if (frame_press !== 8'h02) begin
            errors++; $display("FAIL coincide_publish: got fp=%h exp 02", frame_press);
        end
        repeat (2) step(8'h00, 1'b0);
    endtask

    task automatic test_reset_mid();
        int npress = 0; int pstep = -1; logic [7:0] pval = 8'h00;
        repeat (6) step(8'h28, 1'b0);
        checks++;
        if (action_held !== 8'h40 || accepted_code !== 8'h28) begin
            errors++; $display("FAIL reset_mid_setup: got held=%h acc=%h exp held=40 acc=28", action_held, accepted_code);
        end
        #2 Reset = 1'b0;
        #1;
        checks++;
        if (dut_vec !== 33'd0) begin
            errors++; $display("FAIL reset_mid_async: got=%h exp=%h", dut_vec, 33'd0);
        end
        model_reset();
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            step(8'h28, 1'b1);
            checks++;
            if (dut_vec !== mdl_vec) begin
                errors++; $display("FAIL reset_mid_after step%0d: got=%h exp=%h", i, dut_vec, mdl_vec);
            end
            if (i == 4 && frame_press !== 8'h00) begin
                errors++; $display("FAIL reset_sticky_cleared: got fp=%h exp 00", frame_press);
            end
            if (action_press != 8'h00) begin npress++; pstep = i; pval = action_press; end
        end
        checks++;
        if (npress != 1 || pstep != int'(SC) + 1 || pval !== 8'h40) begin
            errors++; $display("FAIL reset_mid_repress: got count=%0d step=%0d val=%h exp count=1 step=%0d val=40", npress, pstep, pval, int'(SC) + 1);
        end
    endtask

    task automatic test_random();
        logic [7:0] pool [0:10];
        logic [7:0] kc;
        logic       v;
        int         len;
        pool = '{8'h00, 8'h04, 8'h07, 8'h1A, 8'h50, 8'h4F, 8'h52, 8'h28, 8'h2C, 8'h1D, 8'h33};
        v = 1'b0;
        for (int n = 0; n < 250; n++) begin
            kc  = pool[$urandom_range(0, 10)];
            len = $urandom_range(1, 7);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 3) == 0) v = ~v;
                step(kc, v);
                checks++;
                if (dut_vec !== mdl_vec) begin
                    errors++; $display("FAIL random n%0d i%0d kc=%h: got=%h exp=%h", n, i, kc, dut_vec, mdl_vec);
                end
            end
            if ($urandom_range(0, 49) == 0) begin
                #2 Reset = 1'b0;
                #1;
                checks++;
                if (dut_vec !== 33'd0) begin
                    errors++; $display("FAIL random_reset n%0d: got=%h exp=%h", n, dut_vec, 33'd0);
                end
                model_reset();
                @(negedge Clk);
                Reset = 1'b1;
                v = 1'b0;
            end
        end
    endtask

    initial begin
        m_cycle = 0;
        model_reset();
        Reset   = 1'b0;
        keycode = 8'h00;
        vs      = 1'b0;
        test_reset();
        test_stable_press();
        test_bounce();
        test_direct_change();
        test_unmapped();
        test_frame();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
